// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-source / bit-pattern detector family.
//   piso_state_t : two-state controller encoding for piso_bit_source
//   PISO_WIDTH   : default word length; also sizes the detectors' test words
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_WIDTH = 8;

endpackage

// File: rtl/piso_bit_source.sv
// Parallel-in, serial-out bit source feeding a bit-pattern detector's x input.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock,
// gapless across back-to-back words. Drives IDLE_BIT between words.
//
// Parameters:
//   WIDTH     : word length in bits (>= 1)
//   MSB_FIRST : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
//   IDLE_BIT  : level on x_out when no word is in flight
// Ports:
//   clk       : clock, all logic on rising edge
//   rst       : synchronous active-high reset
//   in_data   : word to serialize, sampled on the accepting edge
//   in_valid  : in_data is valid
//   in_ready  : a word can be accepted this cycle
//   x_out     : serial bit stream
//   bit_valid : x_out carries a data bit
//   last_bit  : x_out is the final bit of the current word
//   busy      : a word is being shifted out
module piso_bit_source
    import serial_pkg::*;
#(
    parameter int   WIDTH     = PISO_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sr_reg;

    logic at_last;
    logic xfer;
    logic head;

    // cnt_reg is held at 0 in IDLE, so for WIDTH = 1 at_last is permanently
    // true and in_ready never drops.
    assign at_last   = (cnt_reg == LAST_CNT);
    assign in_ready  = (state_reg == IDLE) || at_last;
    assign xfer      = in_valid && in_ready;

    assign head      = MSB_FIRST ? sr_reg[WIDTH-1] : sr_reg[0];
    assign bit_valid = (state_reg == SHIFT);
    assign busy      = (state_reg == SHIFT);
    assign last_bit  = (state_reg == SHIFT) && at_last;
    assign x_out     = (state_reg == SHIFT) ? head : IDLE_BIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        sr_reg    <= in_data;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        // Move the next bit into the head position.
                        if (MSB_FIRST) begin
                            sr_reg <= sr_reg << 1;
                        end else begin
                            sr_reg <= sr_reg >> 1;
                        end
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (xfer) begin
                        // Reload on the last-bit edge keeps the stream gapless.
                        sr_reg  <= in_data;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/piso_bit_source.md
# piso_bit_source

Parallel-in, serial-out bit source that feeds the serial input of the team's bit-pattern detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `x_out`, gapless across back-to-back words. Between words it drives a fixed idle level so the downstream detector always sees a defined bit every cycle.

## Interface
- `WIDTH`, 8, word length in bits, 1 or greater
- `MSB_FIRST`, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first
- `IDLE_BIT`, 0, level driven on `x_out` when no word is in flight
- `clk`  in  1  the block's single clock; all logic is on its rising edge
- `rst`  in  1  reset; synchronous and active-high
- `in_data`  in  WIDTH  word to serialize; sampled on the accepting edge
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block can accept a word this cycle
- `x_out`  out  1  serial bit stream; connects to the detector's `x`
- `bit_valid`  out  1  `x_out` carries a data bit, not idle
- `last_bit`  out  1  `x_out` is the final bit of the current word
- `busy`  out  1  a word is being shifted out

## Operation
- FSM has two states: IDLE and SHIFT. It uses a shift register of WIDTH bits and a bit counter `cnt` of max(1, $clog2(WIDTH)) bits.
- A transfer happens on a rising edge where `in_valid && in_ready` is true.
- `in_ready` is combinational from state and `cnt` only. It never depends on `in_valid`.
  - In IDLE: `in_ready` = 1.
  - In SHIFT: `in_ready` = (`cnt` == WIDTH-1).
- IDLE:
  - On transfer, load `in_data`, set `cnt` = 0 and go to SHIFT.
  - Otherwise `x_out` = IDLE_BIT, `bit_valid` = 0, `last_bit` = 0, `busy` = 0.
- SHIFT:
  - `x_out` = current head bit: the MSB of the shift register if MSB_FIRST, else the LSB.
  - `bit_valid` = 1, `busy` = 1, `last_bit` = (`cnt` == WIDTH-1).
  - Each edge with `cnt` < WIDTH-1: shift toward the head and increment `cnt`.
- At `cnt` == WIDTH-1:
  - If a transfer occurs, reload, set `cnt` = 0 and stay in SHIFT. There is no idle gap between words.
  - Otherwise go to IDLE.
- `x_out` and `bit_valid` are combinational from registered state only. They never depend on `in_valid` or `in_data` in the same cycle.
- WIDTH = 1:
  - Every data bit is the last bit, and `in_ready` stays 1 throughout.
  - A continuously valid source yields one word per cycle with no gaps.
- `in_data` changing while `in_ready` = 0 has no effect.

## Timing
- Reset values:
  - State IDLE, `cnt` = 0, shift register all zeros.
  - `x_out` = IDLE_BIT, `bit_valid` = 0, `last_bit` = 0, `busy` = 0, `in_ready` = 1.
- Latency: a word accepted on edge k puts its first bit on `x_out` in the cycle after edge k. Its last bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one bit per cycle. A word occupies exactly WIDTH cycles of `x_out`.
- Back-to-back: a transfer on the edge that ends the last-bit cycle puts the new word's first bit on `x_out` in the very next cycle.
- Reset mid-word:
  - The in-flight word is discarded and no partial bits follow.
  - The cycle after the reset edge shows the reset values.
- Reset asserted together with a transfer: reset wins and the word is not accepted.
- `last_bit` is high for exactly one cycle per word.

## Structure
- Shared package `serial_pkg` holds:
  - The two-state `piso_state_t` typedef (IDLE, SHIFT).
  - The default `WIDTH` constant. The same constant also sizes the companion detectors' test words.
- The block is a single module with no sub-module. The counter and shifter are too small to separate.

## Test plan
- Reset, then hold `in_valid` = 0 for 5 cycles → every cycle shows `x_out` = 0, `bit_valid` = 0, `in_ready` = 1, `busy` = 0.
- WIDTH=8, MSB_FIRST=1, one transfer of 8'hA0:
  - `x_out` = 1,0,1,0,0,0,0,0 on cycles 1–8 after the accepting edge, with `last_bit` high only on cycle 8.
  - Then idle: `x_out` = 0, `bit_valid` = 0.
- MSB_FIRST=0, transfer 8'h05 → `x_out` = 1,0,1,0,0,0,0,0. A downstream 101 detector sees the pattern within the first three bits.
- Back-to-back transfers of 8'hFF then 8'h00, with `in_valid` held high → 16 consecutive `bit_valid` cycles with no gap and `in_ready` high only on cycles 8 and 16.
- `rst` pulsed for one cycle on the 4th bit of 8'hA5 → the next cycle shows the reset values, and the remaining bits never appear.
- WIDTH=1 with `in_valid` held high and data 1,0,1 → `x_out` = 1,0,1 on consecutive cycles, with `last_bit` = 1 and `in_ready` = 1 every cycle.
